pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush scheduler: load-use bubbles, bus wait states, jump flushes.
// Optional stall counter port enabled by defining PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_load_en,
  input  logic [4:0] ex_rd_addr,
  input  logic       jmp_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_hold_n,
  output logic       if_id_hold_n,
  output logic       id_ex_hold_n,
  output logic       ex_mem_hold_n,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       bus_err
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    JMP_FLUSH
  } state_t;

  state_t     state;
  logic       jmp_pend;
  logic [7:0] wait_cnt;

  logic lu;
  logic mem_stall;
  logic timeout;

  always_comb begin
    lu = ex_load_en && (ex_rd_addr != 5'd0) &&
         ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
          (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
  end

  assign mem_stall = mem_req && !mem_ready;

  // wait_cnt lags the held-cycle count by one (the entry cycle also holds)
  assign timeout = (state == MEM_WAIT) && !mem_ready &&
                   (({1'b0, wait_cnt} + 9'd1) == 9'(MEM_TIMEOUT));

  always_comb begin
    pc_hold_n     = 1'b1;
    if_id_hold_n  = 1'b1;
    id_ex_hold_n  = 1'b1;
    ex_mem_hold_n = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    bus_err       = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            pc_hold_n     = 1'b0;
            if_id_hold_n  = 1'b0;
            id_ex_hold_n  = 1'b0;
            ex_mem_hold_n = 1'b0;
          end else if (jmp_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            pc_hold_n    = 1'b0;
            if_id_hold_n = 1'b0;
            id_ex_flush  = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready && !timeout) begin
            pc_hold_n     = 1'b0;
            if_id_hold_n  = 1'b0;
            id_ex_hold_n  = 1'b0;
            ex_mem_hold_n = 1'b0;
          end
          bus_err = timeout;
        end
        JMP_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      jmp_pend <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
            jmp_pend <= jmp_taken;
          end
        end
        MEM_WAIT: begin
          if (mem_ready || timeout) begin
            state    <= jmp_pend ? JMP_FLUSH : RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        JMP_FLUSH: begin
          state    <= RUN;
          jmp_pend <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (!pc_hold_n && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed literal checks plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, ex_load_en;
  logic       jmp_taken, mem_req, mem_ready;
  logic       pc_hold_n, if_id_hold_n, id_ex_hold_n, ex_mem_hold_n;
  logic       if_id_flush, id_ex_flush, bus_err;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_load_en(ex_load_en),
    .ex_rd_addr(ex_rd_addr),
    .jmp_taken(jmp_taken),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .pc_hold_n(pc_hold_n),
    .if_id_hold_n(if_id_hold_n),
    .id_ex_hold_n(id_ex_hold_n),
    .ex_mem_hold_n(ex_mem_hold_n),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .bus_err(bus_err)
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // {pc, if_id, id_ex, ex_mem hold_n, if_id_flush, id_ex_flush, bus_err}
  function automatic logic [6:0] outs();
    return {pc_hold_n, if_id_hold_n, id_ex_hold_n, ex_mem_hold_n,
            if_id_flush, id_ex_flush, bus_err};
  endfunction

  localparam logic [6:0] GO    = 7'b1111_00_0;
  localparam logic [6:0] HOLD  = 7'b0000_00_0;
  localparam logic [6:0] FLUSH = 7'b1111_11_0;
  localparam logic [6:0] BUBL  = 7'b0011_01_0;
  localparam logic [6:0] BERR  = 7'b1111_00_1;

  // Behavioural model: tracks whether a bus wait is in progress, how many
  // cycles have been held so far, and whether a jump flush is owed.
  bit          m_wait = 0;
  bit          m_pend = 0;
  bit          m_flush = 0;
  int          m_held = 0;
  longint      m_stalls = 0;
  logic [6:0]  m_exp;
  bit          m_lu;

  always @(negedge clk) begin
    m_lu = ex_load_en && ex_rd_addr != 0 &&
           ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
            (id_rs2_used && id_rs2_addr == ex_rd_addr));
    if (rst) begin
      m_exp = GO;
      m_wait = 0; m_pend = 0; m_flush = 0; m_held = 0;
    end else if (m_flush) begin
      m_exp = FLUSH;
      m_flush = 0;
    end else if (m_wait) begin
      if (mem_ready) begin
        m_exp = GO;
        m_wait = 0; m_flush = m_pend; m_pend = 0;
      end else if (m_held == TO) begin
        m_exp = BERR;
        m_wait = 0; m_flush = m_pend; m_pend = 0;
      end else begin
        m_exp = HOLD;
        m_held++;
      end
    end else if (mem_req && !mem_ready) begin
      m_exp = HOLD;
      m_wait = 1; m_held = 1; m_pend = jmp_taken;
    end else if (jmp_taken) begin
      m_exp = FLUSH;
    end else if (m_lu) begin
      m_exp = BUBL;
    end else begin
      m_exp = GO;
    end
    tests++;
    if (outs() !== m_exp) begin
      fails++;
      $display("FAIL model_cmp t=%0t got=%b want=%b", $time, outs(), m_exp);
    end
`ifdef PIPE_CTRL_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 32'(m_stalls)) begin
      fails++;
      $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, m_stalls);
    end
    if (rst) m_stalls = 0;
    else if (m_exp[6] == 1'b0 && m_stalls < 64'hFFFF_FFFF) m_stalls++;
`endif
  end

  task automatic set_in(bit r, bit ld, int rd, bit u1, int a1, bit u2, int a2,
                        bit j, bit rq, bit rdy);
    rst = r; ex_load_en = ld; ex_rd_addr = 5'(rd);
    id_rs1_used = u1; id_rs1_addr = 5'(a1);
    id_rs2_used = u2; id_rs2_addr = 5'(a2);
    jmp_taken = j; mem_req = rq; mem_ready = rdy;
  endtask

  task automatic lit(string name, logic [6:0] exp);
    @(negedge clk);
    tests++;
    if (outs() !== exp) begin
      fails++;
      $display("FAIL %s got=%b want=%b", name, outs(), exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(bit r);
    set_in(r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle(1);
    lit("reset0", GO);
    lit("reset1", GO);
    // load-use on rs1
    set_in(0, 1, 5, 1, 5, 0, 0, 0, 0, 0);
    lit("lu_rs1", BUBL);
    idle(0);
    lit("lu_clear", GO);
    // load-use on rs2
    set_in(0, 1, 9, 1, 3, 1, 9, 0, 0, 0);
    lit("lu_rs2", BUBL);
    // rd = x0 never stalls
    set_in(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    lit("lu_x0", GO);
    // matching address but unused source
    set_in(0, 1, 7, 0, 7, 0, 7, 0, 0, 0);
    lit("lu_unused", GO);
    // taken jump
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("jmp", FLUSH);
    idle(0);
    lit("jmp_once", GO);
    // jump beats load-use
    set_in(0, 1, 5, 1, 5, 0, 0, 1, 0, 0);
    lit("jmp_over_lu", FLUSH);
    // bus wait, ready after 3 cycles
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lit("bus_w0", HOLD);
    lit("bus_w1", HOLD);
    lit("bus_w2", HOLD);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    lit("bus_rel", GO);
    idle(0);
    lit("bus_after", GO);
    // jump together with stall entry
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    lit("jw_entry", HOLD);
    idle(0);
    lit("jw_w1", HOLD);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lit("jw_rel", GO);
    idle(0);
    lit("jw_flush", FLUSH);
    lit("jw_run", GO);
    // jump is ignored while waiting
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lit("jig_entry", HOLD);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    lit("jig_w1", HOLD);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lit("jig_rel", GO);
    idle(0);
    lit("jig_noflush", GO);
    // timeout after TO held cycles
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lit("to_h0", HOLD);
    idle(0);
    for (int i = 1; i < TO; i++) lit("to_hold", HOLD);
    lit("to_berr", BERR);
    lit("to_run", GO);
    // reset mid-wait with a pending jump
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    lit("rw_entry", HOLD);
    idle(0);
    lit("rw_w1", HOLD);
    idle(1);
    lit("rw_rst", GO);
    idle(0);
    lit("rw_noflush", GO);
    lit("rw_run", GO);
    // ready and jump together in RUN
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    lit("rdy_jmp", FLUSH);
    idle(0);
    lit("rdy_jmp_after", GO);
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      set_in($urandom_range(199) == 0,
             $urandom_range(2) == 0, $urandom_range(3),
             $urandom_range(1) == 0, $urandom_range(3),
             $urandom_range(1) == 0, $urandom_range(3),
             $urandom_range(5) == 0,
             $urandom_range(5) == 0,
             $urandom_range(4) == 0);
      @(posedge clk); #1;
    end
    idle(0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
